mem_port_arbiter: RTL and testbench

//  Shares one single-ported, word-wide synchronous memory between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: LS over IF, sub-word stores as read-modify-write, sub-word load extraction.
// Optional macro STARVE_GUARD_EN forces an IF grant after STARVE_MAX consecutive denied ARB cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_flush,
  output logic              o_if_gnt,
  output logic              o_if_stall,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_wren,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [31:0]       i_ls_wdata,
  input  logic [1:0]        i_ls_op,
  input  logic              i_ls_un,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [31:0]       o_ls_rdata,
  output logic              o_mem_en,
  output logic              o_mem_wren,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic {ARB, RMW_MRG} state_e;

  state_e            state_q, state_d;
  logic              if_pend_q, if_pend_d;
  logic              ld_pend_q, ld_pend_d;
  logic              st_ack_q, st_ack_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        lo_q, lo_d;
  logic              un_q, un_d;
  logic [ADDR_W-3:0] widx_q, widx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              if_gnt, ls_gnt, force_if;
  logic [31:0]       merged, ld_ext, ls_now;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              unused_if_lo;

  assign unused_if_lo = ^i_if_addr[1:0];

`ifdef STARVE_GUARD_EN
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q, starve_d;

  assign force_if = (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (if_gnt)
      starve_d = '0;
    else if (i_reset_n && state_q == ARB && i_if_req && starve_q != STARVE_LIM)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) starve_q <= '0;
    else            starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ARB;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (ls_gnt && i_ls_wren && i_ls_op[1]) state_d = RMW_MRG;
      RMW_MRG: state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Write-back word for the RMW cycle: captured lane(s) over the word just read.
  always_comb begin
    merged = i_mem_rdata;
    if (op_q[0]) merged[{lo_q, 3'b000} +: 8]     = wdata_q[7:0];
    else         merged[{lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Grants and memory port; everything held low while reset is asserted.
  always_comb begin
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_wren  = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_reset_n) begin
      case (state_q)
        ARB: begin
          if (i_if_req && (force_if || !i_ls_req)) begin
            if_gnt     = 1'b1;
            o_mem_en   = 1'b1;
            o_mem_addr = i_if_addr[ADDR_W-1:2];
          end else if (i_ls_req) begin
            ls_gnt      = 1'b1;
            o_mem_en    = 1'b1;
            o_mem_wren  = i_ls_wren & ~i_ls_op[1];
            o_mem_addr  = i_ls_addr[ADDR_W-1:2];
            o_mem_wdata = i_ls_wdata;
          end
        end
        RMW_MRG: begin
          o_mem_en    = 1'b1;
          o_mem_wren  = 1'b1;
          o_mem_addr  = widx_q;
          o_mem_wdata = merged;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = i_mem_rdata[{lo_q, 3'b000} +: 8];
    ld_half = i_mem_rdata[{lo_q[1], 4'b0000} +: 16];
    if (!op_q[1])    ld_ext = i_mem_rdata;
    else if (op_q[0]) ld_ext = {{24{ld_byte[7] & ~un_q}}, ld_byte};
    else              ld_ext = {{16{ld_half[15] & ~un_q}}, ld_half};
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_if_stall  = i_reset_n & i_if_req & ~if_gnt;
  assign o_if_rvalid = if_pend_q & ~i_flush;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : if_rdata_q;
  assign o_ls_rvalid = ld_pend_q | st_ack_q;
  assign ls_now      = ld_pend_q ? ld_ext : '0;
  assign o_ls_rdata  = o_ls_rvalid ? ls_now : ls_rdata_q;

  always_comb begin
    if_pend_d  = if_gnt & ~i_flush;
    ld_pend_d  = ls_gnt & ~i_ls_wren;
    st_ack_d   = (ls_gnt & i_ls_wren & ~i_ls_op[1]) | (state_q == RMW_MRG);
    op_d       = op_q;
    lo_d       = lo_q;
    un_d       = un_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    if (ls_gnt) begin
      op_d    = i_ls_op;
      lo_d    = i_ls_addr[1:0];
      un_d    = i_ls_un;
      widx_d  = i_ls_addr[ADDR_W-1:2];
      wdata_d = i_ls_wdata;
    end
    if_rdata_d = o_if_rdata;
    ls_rdata_d = o_ls_rdata;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      if_pend_q  <= 1'b0;
      ld_pend_q  <= 1'b0;
      st_ack_q   <= 1'b0;
      op_q       <= '0;
      lo_q       <= '0;
      un_q       <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if_pend_q  <= if_pend_d;
      ld_pend_q  <= ld_pend_d;
      st_ack_q   <= st_ack_d;
      op_q       <= op_d;
      lo_q       <= lo_d;
      un_q       <= un_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors push expected responses, a monitor pops them.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 1 << (ADDR_W - 2);
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              if_req = 1'b0, flush = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              ls_req = 1'b0, ls_wren = 1'b0, ls_un = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [31:0]       ls_wdata = '0;
  logic [1:0]        ls_op = '0;
  logic              o_if_gnt, o_if_stall, o_if_rvalid, o_ls_gnt, o_ls_rvalid;
  logic              o_mem_en, o_mem_wren;
  logic [31:0]       o_if_rdata, o_ls_rdata, o_mem_wdata;
  logic [ADDR_W-3:0] o_mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic [31:0]       mem [0:DEPTH-1];
  logic              preload = 1'b1;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_flush(flush),
    .o_if_gnt(o_if_gnt), .o_if_stall(o_if_stall), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(ls_req), .i_ls_wren(ls_wren), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ls_op(ls_op), .i_ls_un(ls_un),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_en(o_mem_en), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      mem[3] <= 32'h0000_0000;
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'h8011_2233;
    end else if (o_mem_en) begin
      if (o_mem_wren) mem[o_mem_addr] <= o_mem_wdata;
      else            mem_rdata <= mem[o_mem_addr];
    end
  end

  typedef struct packed { logic [ADDR_W-3:0] idx; logic [31:0] data; } wr_t;
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  wr_t         wr_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({o_if_gnt, o_if_stall, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid,
                 o_ls_rdata, o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata});
  endfunction

  always @(negedge clk) begin
    if (rst_n && !preload) begin
      if (o_if_rvalid) begin
        if (if_q.size() == 0) check("if_unexpected_rvalid", 1, 0);
        else check("if_rdata", o_if_rdata, if_q.pop_front());
      end
      if (o_ls_rvalid) begin
        if (ls_q.size() == 0) check("ls_unexpected_rvalid", 1, 0);
        else check("ls_rdata", o_ls_rdata, ls_q.pop_front());
      end
      if (o_mem_en && o_mem_wren) begin
        if (wr_q.size() == 0) check("mem_unexpected_write", 1, 0);
        else check("mem_write", {o_mem_addr, o_mem_wdata}, wr_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; ls_req = 1'b0; flush = 1'b0; ls_wren = 1'b0;
  endtask

  task automatic ls_drive(input logic wren, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wd, input logic [1:0] op, input logic un);
    ls_req = 1'b1; ls_wren = wren; ls_addr = addr; ls_wdata = wd; ls_op = op; ls_un = un;
  endtask

  function automatic wr_t wr(input logic [ADDR_W-3:0] idx, input logic [31:0] d);
    wr_t w;
    w.idx = idx; w.data = d;
    return w;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    preload = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs(), '0);
    cyc(); rst_n = 1'b1;

    // IF only
    cyc(); if_req = 1'b1; if_addr = 16'h0010; if_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("if_gnt", o_if_gnt, 1); check("if_mem_addr", {o_mem_en, o_mem_addr}, {1'b1, 14'd4});
    check("if_stall_granted", o_if_stall, 0);
    cyc(); idle();
    @(negedge clk); check("if_rvalid_latency", o_if_rvalid, 1);

    // loads from mem[8] = 0x80112233
    cyc(); ls_drive(0, 16'h0023, '0, 2'b11, 0); ls_q.push_back(32'hFFFF_FF80);
    @(negedge clk); check("lb_gnt", o_ls_gnt, 1);
    cyc(); ls_drive(0, 16'h0023, '0, 2'b11, 1); ls_q.push_back(32'h0000_0080);
    @(negedge clk); check("lb_rvalid_latency", o_ls_rvalid, 1);
    cyc(); ls_drive(0, 16'h0022, '0, 2'b10, 0); ls_q.push_back(32'hFFFF_8011);
    cyc(); ls_drive(0, 16'h0021, '0, 2'b10, 1); ls_q.push_back(32'h0000_2233);
    cyc(); ls_drive(0, 16'h0020, '0, 2'b00, 0); ls_q.push_back(32'h8011_2233);
    cyc(); ls_drive(1, 16'h0020, 32'h1122_3344, 2'b00, 0);
    wr_q.push_back(wr(14'd8, 32'h1122_3344)); ls_q.push_back('0);
    @(negedge clk); check("sw_wren", o_mem_wren, 1);

    // sub-word store RMW with IF arriving in the merge cycle
    cyc(); ls_drive(1, 16'h0021, 32'h0000_00AB, 2'b11, 0);
    wr_q.push_back(wr(14'd8, 32'h1122_AB44)); ls_q.push_back('0);
    @(negedge clk); check("sb_gnt", o_ls_gnt, 1); check("sb_read_phase", o_mem_wren, 0);
    cyc(); idle(); if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    check("rmw_if_gnt", o_if_gnt, 0); check("rmw_if_stall", o_if_stall, 1);
    check("rmw_no_early_ack", o_ls_rvalid, 0); check("rmw_wren", o_mem_wren, 1);
    cyc(); if_q.push_back(32'hDEAD_BEEF);
    @(negedge clk); check("post_rmw_if_gnt", o_if_gnt, 1); check("sb_ack_latency", o_ls_rvalid, 1);
    cyc(); idle(); ls_drive(1, 16'h000E, 32'h1234_BEEF, 2'b10, 0);
    wr_q.push_back(wr(14'd3, 32'hBEEF_0000)); ls_q.push_back('0);
    cyc(); idle();
    cyc(); ls_drive(0, 16'h000C, '0, 2'b00, 0); ls_q.push_back(32'hBEEF_0000);
    cyc(); ls_drive(0, 16'h0020, '0, 2'b11, 0); ls_q.push_back(32'h0000_0044);
    cyc(); ls_drive(0, 16'h0020, '0, 2'b10, 0); ls_q.push_back(32'hFFFF_AB44);

    // simultaneous requests
    for (int i = 0; i < 6; i++) begin
      cyc(); if_req = 1'b1; if_addr = 16'h0010; ls_drive(0, 16'h0010, '0, 2'b00, 0);
      if (GUARD && i == 4) if_q.push_back(32'hDEAD_BEEF);
      else                 ls_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      check("both_ls_gnt", o_ls_gnt, (GUARD && i == 4) ? 1'b0 : 1'b1);
      check("both_if_gnt", o_if_gnt, (GUARD && i == 4) ? 1'b1 : 1'b0);
      check("both_if_stall", o_if_stall, (GUARD && i == 4) ? 1'b0 : 1'b1);
    end
    cyc(); idle();

    // flush: in flight, then same cycle as grant
    cyc(); if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk); check("flush_if_gnt", o_if_gnt, 1);
    cyc(); idle(); flush = 1'b1;
    @(negedge clk); check("flush_inflight", o_if_rvalid, 0);
    cyc(); idle(); if_req = 1'b1; flush = 1'b1;
    @(negedge clk); check("flush_same_gnt", o_if_gnt, 1);
    cyc(); idle();
    @(negedge clk); check("flush_same_kill", o_if_rvalid, 0);
    cyc(); if_req = 1'b1; if_q.push_back(32'hDEAD_BEEF);
    cyc(); idle();
    @(negedge clk); check("post_flush_rvalid", o_if_rvalid, 1);

    // reset during RMW merge
    cyc(); ls_drive(1, 16'h0021, 32'h0000_00CD, 2'b11, 0);
    @(negedge clk); check("sb2_gnt", o_ls_gnt, 1);
    cyc(); idle(); rst_n = 1'b0;
    #1 check("rst_mem_en", o_mem_en, 0);
    @(negedge clk); check("rst_outputs", outs(), '0);
    cyc(); cyc(); rst_n = 1'b1;
    @(negedge clk); check("post_rst_outputs", outs(), '0);
    cyc(); ls_drive(0, 16'h0020, '0, 2'b00, 0); ls_q.push_back(32'h1122_AB44);
    cyc(); idle();
    cyc(); cyc();
    check("queues_drained", 128'(if_q.size() + ls_q.size() + wr_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
